// File: rtl/mips_pkg.sv
// Shared pipeline definitions used by the multi-cycle MULTU/DIVU sequencer.
// Contents:
//   ALU_* : 3-bit control codes of the pipeline's combinational ALU
//   seq_state_t : sequencer FSM states (IDLE -> RUN -> DONE -> IDLE)
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Bundle between the pipeline (EX stage, shared ALU, HI/LO consumers) and
// the MULTU/DIVU sequencer.
//   master : pipeline side; issues start/op_div/opa/opb/flush, returns the
//            shared ALU result, observes busy/done/hi/lo and the ALU request.
//   slave  : sequencer side.
// Signals:
//   start, op_div, opa, opb, flush   request and abort
//   alu_req, alu_a, alu_b, alu_ctrl  sequencer drive of the shared ALU
//   alu_result                       combinational ALU output
//   busy, done, hi, lo               status and results
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             alu_req;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op_div, opa, opb, flush, alu_result,
        input  alu_req, alu_a, alu_b, alu_ctrl, busy, done, hi, lo
    );

    modport slave (
        input  start, op_div, opa, opb, flush, alu_result,
        output alu_req, alu_a, alu_b, alu_ctrl, busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer. Holds no adder of its own: while in RUN
// it drives the pipeline's shared ALU (add for shift-add multiply, subtract
// for restoring division) one iteration per cycle, WIDTH iterations total.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    muldiv_seq_if.slave: request, shared-ALU drive/result, busy,
//          one-cycle done pulse, HI/LO results
module muldiv_seq
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opr_q, opr_d;    // multiplicand or divisor
    logic             div_q, div_d;

    logic             top;
    logic [WIDTH-1:0] rs;
    logic             carry;

    // Restoring-division partial remainder shifted left by one; top is the
    // bit shifted out, which forces a subtract since rs+2^WIDTH > divisor.
    assign top   = hi_q[WIDTH-1];
    assign rs    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    // The ALU sum wraps; an unsigned result smaller than an addend is a carry.
    assign carry = (bus.alu_result < hi_q);

    // Shared ALU drive
    always_comb begin
        bus.alu_req  = 1'b0;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = ALU_ADD;
        if (state_q == RUN) begin
            bus.alu_req = 1'b1;
            if (div_q) begin
                bus.alu_a    = rs;
                bus.alu_b    = opr_q;
                bus.alu_ctrl = ALU_SUB;
            end else begin
                bus.alu_a    = hi_q;
                bus.alu_b    = lo_q[0] ? opr_q : '0;
                bus.alu_ctrl = ALU_ADD;
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opr_d   = opr_q;
        div_d   = div_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    count_d = '0;
                    opr_d   = bus.opb;
                    div_d   = bus.op_div;
                    if (bus.op_div && (bus.opb == '0)) begin
                        hi_d    = bus.opa;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = bus.opa;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (div_q) begin
                        if (top || (rs >= opr_q)) begin
                            hi_d = bus.alu_result;
                            lo_d = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_d = rs;
                            lo_d = {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {hi_d, lo_d} = {carry, bus.alu_result, lo_q[WIDTH-1:1]};
                    end
                    if (count_q == LastCount) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opr_q   <= '0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opr_q   <= opr_d;
            div_q   <= div_d;
        end
    end

    // Status; a flush in DONE swallows the pulse.
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE) && !bus.flush;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural model of
// the shared pipeline ALU.
module tb_muldiv_seq;
    import mips_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   done_cnt;
    int   cycles;
    int   req_cnt;
    int   snap;
    int   guard;

    muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

    muldiv_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU
    always_comb begin
        case (bus.alu_ctrl)
            ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
            ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
            ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
            ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
            default: bus.alu_result = '0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done.
    task automatic run_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                          output int n_cyc, output int n_req);
        bus.start  = 1'b1;
        bus.op_div = div;
        bus.opa    = a;
        bus.opb    = b;
        tick();
        bus.start = 1'b0;
        n_cyc = 1;
        n_req = bus.alu_req ? 1 : 0;
        while (!bus.done && n_cyc < 100) begin
            tick();
            n_cyc++;
            if (bus.alu_req) n_req++;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        done_cnt   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_div = 1'b0;
        bus.opa    = '0;
        bus.opb    = '0;
        bus.flush  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_req", 64'(bus.alu_req), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_ctrl", 64'(bus.alu_ctrl), 64'(3'b010));
        rst_n = 1'b1;
        tick();

        // MULTU 7 x 6
        run_op(1'b0, 32'd7, 32'd6, cycles, req_cnt);
        check("mul7x6_lat", 64'(cycles), 64'd33);
        check("mul7x6_req", 64'(req_cnt), 64'd32);
        check("mul7x6_hilo", {bus.hi, bus.lo}, 64'd42);
        check("mul7x6_busy_in_done", 64'(bus.busy), 64'd1);
        tick();
        check("mul7x6_done_pulse", 64'(bus.done), 64'd0);
        check("mul7x6_idle", 64'(bus.busy), 64'd0);
        repeat (5) tick();
        check("mul7x6_hold", {bus.hi, bus.lo}, 64'd42);

        // MULTU max x max: carry capture
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles, req_cnt);
        check("mulmax_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        tick();

        // DIVU 100 / 7
        run_op(1'b1, 32'd100, 32'd7, cycles, req_cnt);
        check("div100_lat", 64'(cycles), 64'd33);
        check("div100_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
        tick();

        // DIVU 0x80000000 / 3
        run_op(1'b1, 32'h8000_0000, 32'd3, cycles, req_cnt);
        check("div8000_hilo", {bus.hi, bus.lo}, {32'd2, 32'h2AAA_AAAA});
        tick();

        // DIVU 5 / 0
        run_op(1'b1, 32'd5, 32'd0, cycles, req_cnt);
        check("div0_lat", 64'(cycles), 64'd1);
        check("div0_req", 64'(req_cnt), 64'd0);
        check("div0_hilo", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});
        tick();

        // MULTU 3 x 3 with extra starts in RUN and in the done cycle
        snap = done_cnt;
        bus.start = 1'b1; bus.op_div = 1'b0; bus.opa = 32'd3; bus.opb = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.start = 1'b1; bus.opa = 32'd5; bus.opb = 32'd5;
        tick();
        bus.start = 1'b0;
        guard = 0;
        while (!bus.done && guard < 100) begin
            tick();
            guard++;
        end
        check("ign_done_seen", 64'(bus.done), 64'd1);
        bus.start = 1'b1; bus.opa = 32'd5; bus.opb = 32'd5;
        tick();
        bus.start = 1'b0;
        check("ign_idle", 64'(bus.busy), 64'd0);
        check("ign_hilo", {bus.hi, bus.lo}, {32'd0, 32'd9});
        repeat (40) tick();
        check("ign_still_idle", 64'(bus.busy), 64'd0);
        check("ign_one_done", 64'(done_cnt - snap), 64'd1);

        // Flush in RUN
        snap = done_cnt;
        bus.start = 1'b1; bus.op_div = 1'b1; bus.opa = 32'd1000; bus.opb = 32'd9;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_idle", 64'(bus.busy), 64'd0);
        check("flush_req", 64'(bus.alu_req), 64'd0);
        repeat (40) tick();
        check("flush_no_done", 64'(done_cnt - snap), 64'd0);

        // Flush alone in IDLE does nothing
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_idle_noop", 64'(bus.busy), 64'd0);

        // Reset in the middle of a MULTU
        snap = done_cnt;
        bus.start = 1'b1; bus.op_div = 1'b0; bus.opa = 32'd9; bus.opb = 32'd9;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        check("mrst_busy", 64'(bus.busy), 64'd0);
        check("mrst_done", 64'(bus.done), 64'd0);
        check("mrst_req", 64'(bus.alu_req), 64'd0);
        check("mrst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("mrst_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        rst_n = 1'b1;
        repeat (40) tick();
        check("mrst_no_done", 64'(done_cnt - snap), 64'd0);

        run_op(1'b0, 32'd2, 32'd2, cycles, req_cnt);
        check("mul2x2_lat", 64'(cycles), 64'd33);
        check("mul2x2_hilo", {bus.hi, bus.lo}, 64'd4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
